// File: rtl/band_playback_sequencer.sv
// Sequences one sample per band through a valid/ready stream each audio sample period.
// Each band is enabled in turn and waited on for a bounded time before it is skipped.
module band_playback_sequencer #(
  parameter int NUM_BANDS = 16,
  parameter int CLK_DIV   = 100,
  parameter int WAIT_MAX  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [NUM_BANDS-1:0]         band_mask,
  output logic [NUM_BANDS-1:0]         band_enable,
  input  logic [NUM_BANDS-1:0]         band_valid,
  input  logic [NUM_BANDS*16-1:0]      band_data,
  output logic [15:0]                  s_data,
  output logic [$clog2(NUM_BANDS)-1:0] s_band,
  output logic                         s_last,
  output logic                         s_valid,
  input  logic                         s_ready,
  output logic                         frame_tick,
  output logic                         overrun,
  output logic                         timeout_err,
  input  logic                         clr_err
);

  localparam int IDXW = $clog2(NUM_BANDS);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int WCW  = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  logic [DIVW-1:0] div;
  logic [WCW-1:0]  wait_cnt;
  logic            tick;
  logic            last_band;
  logic            wait_expired;

  assign tick         = run && (div == DIVW'(CLK_DIV - 1));
  assign frame_tick   = tick;
  assign last_band    = (idx == IDXW'(NUM_BANDS - 1));
  assign wait_expired = (wait_cnt == WCW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!run || tick) begin
      div <= '0;
    end else begin
      div <= div + DIVW'(1);
    end
  end

  // Stream: a beat transfers on any cycle where s_valid and s_ready are both high;
  // s_data/s_band/s_last are loaded only on entry to SEND, so they hold between beats.
  assign s_valid = (state == S_SEND);

  always_comb begin
    band_enable = '0;
    if (state == S_ISSUE && band_mask[idx]) begin
      band_enable[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      s_data   <= '0;
      s_band   <= '0;
      s_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            idx   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          if (band_mask[idx]) begin
            state <= S_WAIT;
          end else begin
            s_data <= '0;
            s_band <= idx;
            s_last <= last_band;
            state  <= S_SEND;
          end
        end
        S_WAIT: begin
          if (band_valid[idx]) begin
            s_data <= band_data[{idx, 4'b0000} +: 16];
            s_band <= idx;
            s_last <= last_band;
            state  <= S_SEND;
          end else if (wait_expired) begin
            s_data <= '0;
            s_band <= idx;
            s_last <= last_band;
            state  <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          if (s_ready) begin
            if (s_last) begin
              state <= S_IDLE;
            end else begin
              idx   <= idx + IDXW'(1);
              state <= S_ISSUE;
            end
          end
        end
      endcase
    end
  end

  // A set event on the same edge as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (state == S_WAIT && !band_valid[idx] && wait_expired) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/band_playback_sequencer.md
BAND_PLAYBACK_SEQUENCER -- requirements
Module: band_playback_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_BANDS  16   number of band playback channels sequenced
  CLK_DIV    100  clk cycles per audio sample period (4.4 MHz / 44 kHz)
  WAIT_MAX   3    max cycles in WAIT before timeout
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk          in   1               4.4 MHz system clock
  rst_n        in   1               asynchronous, active-low reset
  run          in   1               1 = generate sample ticks and frames
  band_mask    in   NUM_BANDS       1 = band active; 0 = band skipped, zero sample sent
  band_enable  out  NUM_BANDS       one-hot, one-cycle enable strobe to band i
  band_valid   in   NUM_BANDS       valid_out from each band playback unit
  band_data    in   NUM_BANDS*16    signed samples; band i at bits [16i+15:16i]
  s_data       out  16              signed sample to downstream mixer
  s_band       out  $clog2(NUM_BANDS)  band index of s_data
  s_last       out  1               1 on last band of frame
  s_valid      out  1               stream valid
  s_ready      in   1               stream ready
  frame_tick   out  1               one-cycle pulse at each sample-period tick
  overrun      out  1               sticky: tick arrived while frame in progress
  timeout_err  out  1               sticky: active band failed to return valid
  clr_err      in   1               synchronous clear of both sticky flags
REQ-003 Single clock domain (clk); reset asynchronous active-low (rst_n).

Function
REQ-010 Divider counts 0..CLK_DIV-1 while run=1; tick = (div==CLK_DIV-1); wraps to 0; held at 0 while run=0.
REQ-011 frame_tick is high exactly on tick cycles, regardless of FSM state.
REQ-012 FSM states: IDLE, ISSUE, WAIT, SEND.
REQ-013 IDLE: on tick, idx<=0, next state ISSUE; otherwise remain.
REQ-014 ISSUE (1 cycle): if band_mask[idx]=1, band_enable[idx]=1 and next state WAIT; if 0, band_enable all 0, sample<=0, next state SEND.
REQ-015 band_enable is 0 in every state except ISSUE; never more than one bit set.
REQ-016 WAIT: on band_valid[idx]=1, capture band_data slice idx, then SEND; other bands' valid bits are ignored.
REQ-017 WAIT timeout: after WAIT_MAX cycles without valid, sample<=0, timeout_err<=1, then SEND.
REQ-018 SEND: s_valid=1; s_data=sample; s_band=idx; s_last=(idx==NUM_BANDS-1). All s_* held stable until s_ready=1.
REQ-019 SEND handshake (s_valid & s_ready): if s_last, go to IDLE; else idx<=idx+1 and go to ISSUE.
REQ-020 s_valid=0 outside SEND; s_data/s_band/s_last hold last values.
REQ-021 Latency with s_ready=1 and unmasked band responding in 1 cycle: tick at T; ISSUE at T+1; band_valid at T+2 (WAIT); s_valid at T+3; 3 cycles/band; 48-cycle frame at NUM_BANDS=16.
REQ-022 Tick in any state except IDLE: overrun<=1; tick dropped; frame in progress unaffected.
REQ-023 run deasserted mid-frame: current frame completes normally; no new frame starts.
REQ-024 clr_err and a set event in the same cycle: set wins.
REQ-025 Samples pass through unmodified (no scaling or saturation), sign preserved.

Reset
REQ-030 rst_n=0 forces immediately: state IDLE, idx=0, div=0, band_enable=0, s_valid=0, s_data=0, s_band=0, s_last=0, frame_tick=0, overrun=0, timeout_err=0.
REQ-031 Reset mid-frame aborts the frame; the first frame after release starts on the next tick (CLK_DIV cycles after run=1).

Verification
REQ-040 run=1, mask=all 1s, bands respond 1 cycle after enable, s_ready=1, band i data=0x0100+i -> 16 beats, s_data=0x0100..0x010F, s_band=0..15, s_last only on beat 15, first s_valid at tick+3.
REQ-041 mask=0xFFFE -> band 0 never enabled; beat 0 s_data=0x0000; beats 1..15 carry band data; no timeout_err.
REQ-042 Band 5 never returns valid -> after 3 WAIT cycles, beat 5 s_data=0, timeout_err=1; clr_err=1 -> timeout_err=0 next cycle.
REQ-043 s_ready held 0 for 120 cycles during beat 3 -> s_* stable throughout; next tick sets overrun=1; frame completes with all 16 beats in order.
REQ-044 rst_n pulsed low during WAIT of band 7 -> all outputs 0 immediately; after release with run=1, next frame starts at idx=0, first frame_tick 100 cycles later.
REQ-045 run dropped at beat 10 -> beats 10..15 still delivered; no further frame_tick or band_enable.
